// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default component format, {real, imag}
// pack helpers and the saturation limits also used by the butterfly adder.
package fft_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int FRAC_W_DEF = 0;

  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] re;
    logic signed [DATA_W_DEF-1:0] im;
  } cplx_t;

  function automatic logic [2*DATA_W_DEF-1:0] pack_cplx(
    input logic signed [DATA_W_DEF-1:0] re,
    input logic signed [DATA_W_DEF-1:0] im
  );
    return {re, im};
  endfunction

  function automatic cplx_t unpack_cplx(input logic [2*DATA_W_DEF-1:0] v);
    return cplx_t'(v);
  endfunction

  // Saturation limits for a w-bit signed component.
  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Round-half-up constant for a given fraction width; zero for integers.
  function automatic longint rnd_const(input int frac);
    if (frac > 0) return 64'sd1 <<< (frac - 1);
    return 64'sd0;
  endfunction

endpackage

// File: rtl/complex_mul_pipe_if.sv
// Operand/result handshake bundle for the pipelined complex multiplier.
interface complex_mul_pipe_if
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [2*DATA_W-1:0] i_A;
  logic [2*DATA_W-1:0] i_B;
  logic                i_conj;
  logic                i_valid;
  logic                o_ready;
  logic [2*DATA_W-1:0] o_prod;
  logic                o_ovf;
  logic                o_valid;
  logic                i_ready;

  modport slave (
    input  i_A, i_B, i_conj, i_valid, i_ready,
    output o_ready, o_prod, o_ovf, o_valid
  );

  modport master (
    output i_A, i_B, i_conj, i_valid, i_ready,
    input  o_ready, o_prod, o_ovf, o_valid
  );
endinterface

// File: rtl/sat_round.sv
// Per-component round-half-up, arithmetic shift by FRAC_W and saturation
// to DATA_W bits, flagging any clip.
module sat_round
  import fft_pkg::*;
#(
  parameter int IN_W   = 18,
  parameter int DATA_W = 8,
  parameter int FRAC_W = 0
) (
  input  logic signed [IN_W-1:0]   din,
  output logic signed [DATA_W-1:0] dout,
  output logic                     ovf
);
  localparam logic signed [IN_W:0] RND    = (IN_W+1)'(rnd_const(FRAC_W));
  localparam logic signed [IN_W:0] SAT_HI = (IN_W+1)'(sat_max(DATA_W));
  localparam logic signed [IN_W:0] SAT_LO = (IN_W+1)'(sat_min(DATA_W));

  // One guard bit so adding the rounding constant can never wrap.
  logic signed [IN_W:0] rounded;
  logic signed [IN_W:0] shifted;

  always_comb begin
    rounded = {din[IN_W-1], din} + RND;
    shifted = rounded >>> FRAC_W;
    dout    = shifted[DATA_W-1:0];
    ovf     = 1'b0;
    if (shifted > SAT_HI) begin
      dout = SAT_HI[DATA_W-1:0];
      ovf  = 1'b1;
    end else if (shifted < SAT_LO) begin
      dout = SAT_LO[DATA_W-1:0];
      ovf  = 1'b1;
    end
  end
endmodule

// File: rtl/complex_mul_pipe.sv
// Three-stage complex multiplier (optional conjugate of B) with rounding,
// saturation and a single global stall term shared by every stage.
module complex_mul_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  complex_mul_pipe_if.slave bus
);
  localparam int PROD_W = 2*DATA_W + 1;
  localparam int SUM_W  = 2*DATA_W + 2;

  logic adv;
  logic v1, v2, v3;

  logic signed [DATA_W-1:0] ar, ai, br;
  logic signed [DATA_W:0]   bi_n;
  logic signed [DATA_W:0]   bi_ext;

  logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SUM_W-1:0]  re_sum, im_sum;
  logic signed [DATA_W-1:0] re_sat, im_sat;
  logic                     re_ovf, im_ovf;

  assign adv         = ~v3 | bus.i_ready;
  assign bus.o_ready = adv;
  assign bus.o_valid = v3;

  // Extra bit keeps the negation of the most negative value exact.
  assign bi_ext = {bus.i_B[DATA_W-1], bus.i_B[DATA_W-1:0]};

  assign re_sum = SUM_W'(p_rr) - SUM_W'(p_ii);
  assign im_sum = SUM_W'(p_ri) + SUM_W'(p_ir);

  sat_round #(.IN_W(SUM_W), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_sat_re (
    .din  (re_sum),
    .dout (re_sat),
    .ovf  (re_ovf)
  );

  sat_round #(.IN_W(SUM_W), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_sat_im (
    .din  (im_sum),
    .dout (im_sat),
    .ovf  (im_ovf)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      ar         <= '0;
      ai         <= '0;
      br         <= '0;
      bi_n       <= '0;
      p_rr       <= '0;
      p_ii       <= '0;
      p_ri       <= '0;
      p_ir       <= '0;
      bus.o_prod <= '0;
      bus.o_ovf  <= 1'b0;
    end else if (adv) begin
      v1   <= bus.i_valid;
      ar   <= bus.i_A[2*DATA_W-1:DATA_W];
      ai   <= bus.i_A[DATA_W-1:0];
      br   <= bus.i_B[2*DATA_W-1:DATA_W];
      bi_n <= bus.i_conj ? -bi_ext : bi_ext;

      v2   <= v1;
      p_rr <= PROD_W'(ar) * PROD_W'(br);
      p_ii <= PROD_W'(ai) * PROD_W'(bi_n);
      p_ri <= PROD_W'(ar) * PROD_W'(bi_n);
      p_ir <= PROD_W'(ai) * PROD_W'(br);

      v3         <= v2;
      bus.o_prod <= {re_sat, im_sat};
      bus.o_ovf  <= re_ovf | im_ovf;
    end
  end
endmodule

// File: tb/tb_complex_mul_pipe.sv
// Bench for complex_mul_pipe: three instances (FRAC_W 0, 6, 7) share one
// stimulus stream; results are compared with an integer reference model.
module tb_complex_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        conj, in_valid, out_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  complex_mul_pipe_if #(.DATA_W(8)) if0 ();
  complex_mul_pipe_if #(.DATA_W(8)) if6 ();
  complex_mul_pipe_if #(.DATA_W(8)) if7 ();

  assign if0.i_A = a;  assign if0.i_B = b;  assign if0.i_conj = conj;
  assign if0.i_valid = in_valid;  assign if0.i_ready = out_ready;
  assign if6.i_A = a;  assign if6.i_B = b;  assign if6.i_conj = conj;
  assign if6.i_valid = in_valid;  assign if6.i_ready = out_ready;
  assign if7.i_A = a;  assign if7.i_B = b;  assign if7.i_conj = conj;
  assign if7.i_valid = in_valid;  assign if7.i_ready = out_ready;

  complex_mul_pipe #(.DATA_W(8), .FRAC_W(0)) u0 (.i_clk(clk), .i_rst(rst), .bus(if0.slave));
  complex_mul_pipe #(.DATA_W(8), .FRAC_W(6)) u6 (.i_clk(clk), .i_rst(rst), .bus(if6.slave));
  complex_mul_pipe #(.DATA_W(8), .FRAC_W(7)) u7 (.i_clk(clk), .i_rst(rst), .bus(if7.slave));

  // Round half up, shift, clip; returns {ovf, value}.
  function automatic logic [8:0] round_clip(input int v, input int frac);
    int r;
    r = v;
    if (frac > 0) r = r + (1 << (frac - 1));
    r = r >>> frac;
    if (r > 127)  return {1'b1, 8'h7F};
    if (r < -128) return {1'b1, 8'h80};
    return {1'b0, r[7:0]};
  endfunction

  // Mathematical complex product; returns {ovf, real, imag}.
  function automatic logic [16:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic cj, input int frac);
    int ar, ai, br, bi, re, im;
    logic [8:0] rr, ri;
    ar = int'($signed(av[15:8]));
    ai = int'($signed(av[7:0]));
    br = int'($signed(bv[15:8]));
    bi = int'($signed(bv[7:0]));
    if (cj) bi = -bi;
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
    rr = round_clip(re, frac);
    ri = round_clip(im, frac);
    return {rr[8] | ri[8], rr[7:0], ri[7:0]};
  endfunction

  // Presents one operand pair and returns the cycles until o_valid (20 = none).
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic cj,
                      output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    a = av; b = bv; conj = cj; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!if0.o_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; conj = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (if0.o_valid !== 1'b0 || if7.o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b/%b expected 0", if0.o_valid, if7.o_valid);
    end
    checks++;
    if (if0.o_prod !== 16'h0 || if7.o_prod !== 16'h0) begin
      errors++; $display("FAIL reset_prod: got %h/%h expected 0000", if0.o_prod, if7.o_prod);
    end
    checks++;
    if (if0.o_ovf !== 1'b0 || if7.o_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_ovf: got %b/%b expected 0", if0.o_ovf, if7.o_ovf);
    end
    checks++;
    if (if0.o_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", if0.o_ready);
    end
  endtask

  task automatic test_basic;
    int lat;
    send({8'd4, 8'd2}, {8'd2, 8'hFF}, 1'b0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    checks++;
    if (if0.o_prod !== 16'h0A00 || if0.o_ovf !== 1'b0) begin
      errors++; $display("FAIL basic_mul: got %h ovf %b expected 0a00 ovf 0", if0.o_prod, if0.o_ovf);
    end
    send({8'd4, 8'd2}, {8'd2, 8'hFF}, 1'b1, lat);
    checks++;
    if (lat !== 3 || if0.o_prod !== 16'h0608 || if0.o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_conj: got %h ovf %b lat %0d expected 0608 ovf 0 lat 3", if0.o_prod, if0.o_ovf, lat);
    end
  endtask

  task automatic test_saturation;
    int lat;
    send(16'h8000, 16'h8000, 1'b0, lat);
    checks++;
    if (lat !== 3 || if0.o_prod !== 16'h7F00 || if0.o_ovf !== 1'b1) begin
      errors++; $display("FAIL sat_frac0: got %h ovf %b expected 7f00 ovf 1", if0.o_prod, if0.o_ovf);
    end
    checks++;
    if (if7.o_prod !== 16'h7F00 || if7.o_ovf !== 1'b1) begin
      errors++; $display("FAIL sat_frac7: got %h ovf %b expected 7f00 ovf 1", if7.o_prod, if7.o_ovf);
    end
    send({8'hFF, 8'hFE}, {8'hFE, 8'h05}, 1'b0, lat);
    checks++;
    if (lat !== 3 || if7.o_prod !== 16'h0000 || if7.o_ovf !== 1'b0) begin
      errors++; $display("FAIL small_frac7: got %h ovf %b expected 0000 ovf 0", if7.o_prod, if7.o_ovf);
    end
  endtask

  task automatic test_rounding;
    int lat;
    send({8'd64, 8'd0}, {8'd32, 8'd32}, 1'b0, lat);
    checks++;
    if (lat !== 3 || if6.o_prod !== 16'h2020 || if6.o_ovf !== 1'b0) begin
      errors++; $display("FAIL round_unity: got %h ovf %b expected 2020 ovf 0", if6.o_prod, if6.o_ovf);
    end
    send({8'd1, 8'd0}, {8'd32, 8'd0}, 1'b0, lat);
    checks++;
    if (lat !== 3 || if6.o_prod !== 16'h0100) begin
      errors++; $display("FAIL round_half_pos: got %h expected 0100", if6.o_prod);
    end
    send({8'hFF, 8'd0}, {8'd32, 8'd0}, 1'b0, lat);
    checks++;
    if (lat !== 3 || if6.o_prod !== 16'h0000) begin
      errors++; $display("FAIL round_half_neg: got %h expected 0000", if6.o_prod);
    end
  endtask

  task automatic test_back_to_back;
    logic [50:0] exp_q[$];
    logic [50:0] exp_v;
    logic [16:0] got0, got6, got7;
    logic [15:0] held_prod;
    logic        held_ovf, was_stalled, took;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0;
    was_stalled = 1'b0; took = 1'b1; held_prod = '0; held_ovf = 1'b0;
    while ((sent < 16 || recv < 16) && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (was_stalled) begin
        checks++;
        if (if7.o_prod !== held_prod || if7.o_ovf !== held_ovf || if7.o_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold: got %h ovf %b expected %h ovf %b", if7.o_prod, if7.o_ovf, held_prod, held_ovf);
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (took) begin
        if (sent < 16) begin
          a = 16'($urandom); b = 16'($urandom); conj = 1'($urandom);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      checks++;
      if (if0.o_ready !== (!if0.o_valid || out_ready)) begin
        errors++; $display("FAIL ready_term: got %b expected %b", if0.o_ready, !if0.o_valid || out_ready);
      end
      if (if0.o_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL extra_result: got %h expected none", if0.o_prod);
        end else begin
          exp_v = exp_q.pop_front();
          got0 = {if0.o_ovf, if0.o_prod};
          got6 = {if6.o_ovf, if6.o_prod};
          got7 = {if7.o_ovf, if7.o_prod};
          if (got0 !== exp_v[50:34] || got6 !== exp_v[33:17] || got7 !== exp_v[16:0]) begin
            errors++;
            $display("FAIL stream_result %0d: got %h/%h/%h expected %h/%h/%h", recv,
                     got0, got6, got7, exp_v[50:34], exp_v[33:17], exp_v[16:0]);
          end
        end
        recv++;
      end
      took = in_valid && if0.o_ready;
      if (took) begin
        exp_q.push_back({model(a, b, conj, 0), model(a, b, conj, 6), model(a, b, conj, 7)});
        sent++;
      end
      was_stalled = if7.o_valid && !out_ready;
      held_prod   = if7.o_prod;
      held_ovf    = if7.o_ovf;
    end
    in_valid = 1'b0;
    checks++;
    if (recv !== 16 || sent !== 16 || exp_q.size() != 0) begin
      errors++; $display("FAIL stream_count: got sent %0d recv %0d left %0d expected 16 16 0", sent, recv, exp_q.size());
    end
  endtask

  task automatic test_reset_in_flight;
    int lat, stray;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); conj = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    a = {8'd3, 8'd3}; b = {8'd3, 8'd3}; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (if0.o_valid !== 1'b0 || if0.o_ready !== 1'b1) begin
      errors++; $display("FAIL flush_valid: got valid %b ready %b expected 0 1", if0.o_valid, if0.o_ready);
    end
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (if0.o_valid) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL flush_stale: got %0d results expected 0", stray); end
    send({8'd5, 8'hFD}, {8'd2, 8'd7}, 1'b0, lat);
    checks++;
    if (lat !== 3 || if0.o_prod !== {8'd31, 8'd29} || if0.o_ovf !== 1'b0) begin
      errors++; $display("FAIL flush_fresh: got %h lat %0d expected 1f1d lat 3", if0.o_prod, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_reset_in_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/complex_mul_pipe.md
# complex_mul_pipe

Pipelined, parametrised complex multiplier for the FFT butterfly datapath: successor to the combinational `complex_mul`. It keeps the packed `{real, imag}` operand format, but adds:
- generic width with a fixed-point fraction;
- round-half-up and saturation, with an overflow flag;
- a per-sample conjugate mode;
- a valid/ready handshake with full-pipeline stall.

It sits between the twiddle ROM / sample buffer and the butterfly add/sub stage.

## Interface
Parameters:
- DATA_W, 8: width of each real/imag component, signed two's complement.
- FRAC_W, 0: fractional bits of each component (Q(DATA_W-FRAC_W).FRAC_W). Legal range 0..DATA_W-1. 0 gives integer behaviour.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  reset. Synchronous, active-high.
- i_A  in  2*DATA_W  operand A, {real[2*DATA_W-1:DATA_W], imag[DATA_W-1:0]}.
- i_B  in  2*DATA_W  operand B, same packing.
- i_conj  in  1  1: compute A*conj(B); 0: compute A*B. Sampled with the operands.
- i_valid  in  1  operands valid.
- o_ready  out  1  block accepts operands this cycle.
- o_prod  out  2*DATA_W  result, same packing.
- o_ovf  out  1  result real and/or imag saturated; qualified by o_valid.
- o_valid  out  1  o_prod/o_ovf valid.
- i_ready  in  1  downstream accepts result.

## Operation
- Transfer in when i_valid && o_ready. Transfer out when o_valid && i_ready.
- Global stall: `adv = ~o_valid | i_ready`, and o_ready = adv.
  - When adv=0, every stage register (data and valid) holds.
  - Bubbles are not squeezed.
- Stage 1 registers ar, ai, br, and bi' = (i_conj ? -bi : bi).
  - Negate at DATA_W+1 bits, so -(-2^(DATA_W-1)) is exact.
- Stage 2 registers the four signed products ar*br, ai*bi', ar*bi', ai*br at 2*DATA_W+1 bits.
- Stage 3 forms the sums at 2*DATA_W+2 bits:
  - re = ar*br - ai*bi'
  - im = ar*bi' + ai*br
- Stage 3 then, for each component:
  - adds the rounding constant 2^(FRAC_W-1) when FRAC_W>0;
  - arithmetic-shifts right by FRAC_W (round half toward +inf);
  - saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- o_ovf = 1 if either component clipped.
- Results are never truncated by wrap-around. Overflow is always saturation.

## Timing
- Latency 3 cycles from input transfer to o_valid, with no stall.
- Throughput 1 result/cycle while i_ready=1.
- Reset values: o_valid=0, o_prod=0, o_ovf=0, all internal valid bits 0.
  - o_ready=1 in the cycle after reset deasserts, and it is combinational from o_valid/i_ready.
- Reset mid-operation: all in-flight samples are discarded with no partial output. An input presented in the reset cycle is dropped.
- Stall with o_valid=1, i_ready=0:
  - o_prod and o_ovf stay stable.
  - An input offered while o_ready=0 is not taken; the upstream must hold it.
- Simultaneous in and out transfer in one cycle is legal; the pipeline shifts by one.
- o_prod/o_ovf are registered outputs. No combinational path from i_A/i_B to outputs.
- o_ready depends combinationally on i_ready only through the single adv term.

## Structure
- Shared package `fft_pkg` holds:
  - the default DATA_W/FRAC_W;
  - pack/unpack helpers for `{real, imag}`;
  - the saturation-limit constants, which the butterfly adder also uses.
- Natural sub-module: `sat_round`, the per-component round + shift + saturate with an overflow bit. It is instanced twice in stage 3.
- The pipeline valid chain and stall logic stay in the top.

## Test plan
- DATA_W=8, FRAC_W=0, conj=0: A=4+2j, B=2-1j -> o_prod={8'd10, 8'd0}, ovf=0, o_valid exactly 3 cycles after transfer.
- Same operands with conj=1 -> {8'd6, 8'd8}.
- Saturation and flag:
  - FRAC_W=0: A=-128+0j, B=-128+0j -> real saturates to 127, imag 0, ovf=1.
  - FRAC_W=7: same operands -> 127, ovf=1.
  - FRAC_W=7: A=-1-2j, B=-2+5j -> {0, 0}, ovf=0.
- Rounding, FRAC_W=6:
  - A=64+0j (1.0), B=32+32j -> {32, 32}.
  - A=1+0j, B=32+0j -> real 1 (32+32>>6).
  - A=-1+0j, B=32+0j -> real 0 (half rounds up).
- Back-to-back stream of 16 random operands with i_ready toggling pseudo-randomly:
  - results in order, none lost or duplicated;
  - o_prod stable while stalled;
  - results match a reference model.
- Assert i_rst for one cycle with 3 samples in flight -> o_valid=0 the next cycle. A subsequent fresh sample emerges with latency 3. No stale result appears.
